subleq_sequencer: RTL and testbench
===================================

// Module: subleq_sequencer
// PURPOSE
//  Fetch/execute control for the SUBLEQ core. Owns the PC register and drives it to
//  pc_incrementer. Consumes the incrementer's PCout as PC_INC.
//  Per instruction, fetches operands A, B, C, reads mem[A] and mem[B], and writes
//  mem[B]-mem[A] to mem[B]. Branches to C if the result is <= 0, else falls through.
// PARAMETERS
//  AW         8      address/PC width; must equal DW (operands are addresses)
//  DW         8      memory data width
//  HALT_ADDR  8'hFF  a taken branch to this address halts the core
// PORTS
//  CLK        in   1   rising-edge clock, single domain
//  RST_N      in   1   synchronous reset, active low
//  RUN        in   1   start request; sampled only in IDLE
//  PC         out  AW  PC register -> pc_incrementer.PC
//  INC_EN     out  1   -> pc_incrementer.EN; PC_INC is valid the cycle after
//  PC_INC     in   AW  <- pc_incrementer.PCout (PC+1, mod 2^AW)
//  MEM_ADDR   out  AW  memory address; synchronous read, data valid next cycle
//  MEM_DIN    in   DW  memory read data
//  MEM_DOUT   out  DW  write data
//  MEM_WE     out  1   write strobe; write commits at the rising edge
//  HALT       out  1   registered; high in HALTED
// BEHAVIOUR
//  Reset (RST_N low at edge): state=IDLE; PC, A, B, C, MA, R all 0; HALT=0.
//  MEM_WE and INC_EN are combinationally gated by RST_N: no write or increment
//  in a reset cycle, including reset asserted during WB.
//  FSM, one cycle per state. MEM_ADDR=0 and MEM_DOUT=R where not listed.
//   IDLE: RUN=1 -> FA; else stay.
//   FA: ADDR=PC, INC_EN=1 -> LA.
//   LA: A<=MEM_DIN, PC<=PC_INC -> FB.
//   FB: ADDR=PC, INC_EN=1 -> LB.
//   LB: B<=MEM_DIN, PC<=PC_INC -> FC.
//   FC: ADDR=PC, INC_EN=1 -> LC.
//   LC: C<=MEM_DIN, PC<=PC_INC -> RA.
//   RA: ADDR=A -> RB.
//   RB: ADDR=B, MA<=MEM_DIN -> EX.
//   EX: R<=MEM_DIN-MA (DW-bit, wraps, no carry out) -> WB.
//   WB: ADDR=B, DOUT=R, WE=1. If R[DW-1] or R==0, PC<=C (else PC holds orig+3).
//       Taken branch with C==HALT_ADDR -> HALTED; else -> FA.
//   HALTED: HALT=1, WE=0, INC_EN=0; leaves only via reset.
//  Instruction latency: 10 cycles, FA to next FA.
//  RUN is ignored outside IDLE; deasserting it mid-instruction has no effect.
//  PC wrap: an instruction at 0xFD fetches FD, FE, FF; fall-through PC=0x00.
//  A==B is legal: R=0, mem[B]<=0, branch taken.
//  Writes may hit the current instruction's own words. The next fetch sees the
//  new value (self-modifying code supported).
//  A not-taken branch with C==HALT_ADDR does not halt.
// CONFIGURATION
//  SUBLEQ_RETIRE_CNT_EN defined:
//   - adds port RETIRED out 16, reset 0.
//   - increments by 1 in every non-reset WB cycle; saturates at 16'hFFFF.
//   - the halting instruction is counted.
//  SUBLEQ_RETIRE_CNT_EN undefined: port and counter absent; behaviour otherwise identical.
// TESTING
//  1. Hold RST_N low 2 cycles -> PC=0, MEM_WE=0, INC_EN=0, HALT=0; stays IDLE while RUN=0.
//  2. mem[0..2]={10,11,20}, mem[10]=3, mem[11]=5, RUN=1 -> WB: ADDR=11, DOUT=2, WE=1;
//     PC=3 and FA at cycle 10; RETIRED=1 if macro defined.
//  3. mem[10]=5, mem[11]=5 -> DOUT=0, PC=20. mem[10]=6, mem[11]=5 -> DOUT=8'hFF, PC=20.
//  4. Instruction {10,11,8'hFF} with a taken branch -> HALT=1 the next cycle.
//     No further WE/INC_EN for 20 cycles.
//  5. Branch to 0xFD, instruction there not taken -> fetch addrs FD, FE, FF; next FA ADDR=0x00.
//  6. RST_N low during WB of test 2 -> MEM_WE=0 that cycle, mem[11] stays 5,
//     next state IDLE, PC=0.

Source files
------------

// File: rtl/subleq_sequencer.sv
// subleq_sequencer: fetch/execute control for the SUBLEQ core.
// Owns the PC and drives it to pc_incrementer. Each instruction runs in 10 cycles:
// fetch A, B and C, read mem[A] and mem[B], then write mem[B]-mem[A] back to mem[B].
// The core branches to C when the result is <= 0.
// AW must equal DW, because the operands are addresses.
//
// Ports:
//   CLK      in   clock, rising edge
//   RST_N    in   synchronous reset, active low
//   RUN      in   start request, sampled only in IDLE
//   PC       out  PC register, goes to pc_incrementer.PC
//   INC_EN   out  pc_incrementer enable; PC_INC is valid the following cycle
//   PC_INC   in   pc_incrementer.PCout (PC+1)
//   MEM_ADDR out  memory address; read data returns the next cycle
//   MEM_DIN  in   memory read data
//   MEM_DOUT out  memory write data
//   MEM_WE   out  memory write strobe
//   HALT     out  high once a taken branch targets HALT_ADDR
//   RETIRED  out  retired-instruction count, saturating at 16'hFFFF
//                 (present only when SUBLEQ_RETIRE_CNT_EN is defined)
module subleq_sequencer #(
  parameter int unsigned   AW        = 8,
  parameter int unsigned   DW        = 8,
  parameter logic [AW-1:0] HALT_ADDR = '1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          RUN,
  output logic [AW-1:0] PC,
  output logic          INC_EN,
  input  logic [AW-1:0] PC_INC,
  output logic [AW-1:0] MEM_ADDR,
  input  logic [DW-1:0] MEM_DIN,
  output logic [DW-1:0] MEM_DOUT,
  output logic          MEM_WE,
  output logic          HALT
`ifdef SUBLEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]   RETIRED
`endif
);

  localparam int unsigned RCW = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_FA, S_LA, S_FB, S_LB, S_FC, S_LC,
    S_RA, S_RB, S_EX, S_WB, S_HALTED
  } state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q, a_q, b_q, c_q;
  logic [DW-1:0] ma_q, r_q;
  logic          halt_q;
  logic          wb_taken;

  // Branch when the result is negative or zero.
  assign wb_taken = r_q[DW-1] || (r_q == '0);

  // State, operand and datapath registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      ma_q    <= '0;
      r_q     <= '0;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (RUN) state_q <= S_FA;
        S_FA:   state_q <= S_LA;
        S_LA: begin
          a_q     <= AW'(MEM_DIN);
          pc_q    <= PC_INC;
          state_q <= S_FB;
        end
        S_FB:   state_q <= S_LB;
        S_LB: begin
          b_q     <= AW'(MEM_DIN);
          pc_q    <= PC_INC;
          state_q <= S_FC;
        end
        S_FC:   state_q <= S_LC;
        S_LC: begin
          c_q     <= AW'(MEM_DIN);
          pc_q    <= PC_INC;
          state_q <= S_RA;
        end
        S_RA:   state_q <= S_RB;
        S_RB: begin
          ma_q    <= MEM_DIN;
          state_q <= S_EX;
        end
        S_EX: begin
          r_q     <= DW'(MEM_DIN - ma_q);
          state_q <= S_WB;
        end
        S_WB: begin
          state_q <= S_FA;
          if (wb_taken) begin
            pc_q <= c_q;
            if (c_q == HALT_ADDR) begin
              state_q <= S_HALTED;
              halt_q  <= 1'b1;
            end
          end
        end
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Memory and incrementer controls are decoded from the state.
  // Strobes are gated by RST_N so that a reset cycle never writes or increments.
  always_comb begin
    MEM_ADDR = '0;
    case (state_q)
      S_FA, S_FB, S_FC: MEM_ADDR = pc_q;
      S_RA:             MEM_ADDR = a_q;
      S_RB, S_WB:       MEM_ADDR = b_q;
      default:          MEM_ADDR = '0;
    endcase
  end

  assign INC_EN   = RST_N && ((state_q == S_FA) || (state_q == S_FB) || (state_q == S_FC));
  assign MEM_WE   = RST_N && (state_q == S_WB);
  assign MEM_DOUT = r_q;
  assign PC       = pc_q;
  assign HALT     = halt_q;

`ifdef SUBLEQ_RETIRE_CNT_EN
  logic [RCW-1:0] ret_q;

  // Count every write-back, including the halting one, and saturate at the maximum.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ret_q <= '0;
    end else if ((state_q == S_WB) && (ret_q != '1)) begin
      ret_q <= ret_q + RCW'(1);
    end
  end

  assign RETIRED = ret_q;
`endif

endmodule

// File: tb/tb_subleq_sequencer.sv
// Testbench for subleq_sequencer. It includes a behavioural memory with
// synchronous read and a registered pc_incrementer model.
module tb_subleq_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       RUN;
  logic [7:0] PC, PC_INC, MEM_ADDR, MEM_DIN, MEM_DOUT;
  logic       INC_EN, MEM_WE, HALT;
`ifdef SUBLEQ_RETIRE_CNT_EN
  logic [15:0] RETIRED;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [256];
  logic       bd_we = 1'b0;
  logic [7:0] bd_addr = 8'd0;
  logic [7:0] bd_data = 8'd0;

  always #5 CLK = ~CLK;

  subleq_sequencer dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .RUN      (RUN),
    .PC       (PC),
    .INC_EN   (INC_EN),
    .PC_INC   (PC_INC),
    .MEM_ADDR (MEM_ADDR),
    .MEM_DIN  (MEM_DIN),
    .MEM_DOUT (MEM_DOUT),
    .MEM_WE   (MEM_WE),
    .HALT     (HALT)
`ifdef SUBLEQ_RETIRE_CNT_EN
    ,
    .RETIRED  (RETIRED)
`endif
  );

  // Synchronous-read memory; the backdoor port is used only while the DUT is not writing.
  always_ff @(posedge CLK) begin
    if (MEM_WE) mem[MEM_ADDR] <= MEM_DOUT;
    else if (bd_we) mem[bd_addr] <= bd_data;
    MEM_DIN <= mem[MEM_ADDR];
  end

  // pc_incrementer model: PCout registers PC+1 when enabled.
  always_ff @(posedge CLK) begin
    if (INC_EN) PC_INC <= PC + 8'd1;
  end

  typedef struct {
    logic [7:0] op_a, op_b, op_c, va, vb, exp_dout, exp_pc;
  } vec_t;

  vec_t vecs [7];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    tick;
    bd_we   = 1'b0;
  endtask

  // Reset, load the instruction at address 0 and its operands, then start.
  // The task returns in the FA cycle of the first instruction.
  task automatic reset_load_run(input vec_t v);
    RST_N = 1'b0;
    RUN   = 1'b0;
    tick;
    tick;
    poke(8'd0, v.op_a);
    poke(8'd1, v.op_b);
    poke(8'd2, v.op_c);
    poke(v.op_a, v.va);
    poke(v.op_b, v.vb);
    RST_N = 1'b1;
    tick;
    RUN = 1'b1;
    tick;
    RUN = 1'b0;
  endtask

  initial begin
    vec_t v;
    RST_N = 1'b0;
    RUN   = 1'b0;

    // op_a, op_b, op_c, mem[A], mem[B], result, next PC
    vecs[0] = '{8'd10, 8'd11, 8'd20,  8'd3,  8'd5,    8'h02, 8'd3};
    vecs[1] = '{8'd10, 8'd11, 8'd20,  8'd5,  8'd5,    8'h00, 8'd20};
    vecs[2] = '{8'd10, 8'd11, 8'd20,  8'd6,  8'd5,    8'hFF, 8'd20};
    vecs[3] = '{8'd10, 8'd11, 8'd20,  8'd1,  8'h81,   8'h80, 8'd20};
    vecs[4] = '{8'd10, 8'd11, 8'd20,  8'd1,  8'h80,   8'h7F, 8'd3};
    vecs[5] = '{8'd10, 8'd10, 8'd20,  8'd7,  8'd7,    8'h00, 8'd20};
    vecs[6] = '{8'd10, 8'd11, 8'hFF,  8'd3,  8'd5,    8'h02, 8'd3};

    // Reset state, then stay idle while RUN is low.
    tick;
    tick;
    check("rst_pc", 16'(PC), 16'h0);
    check("rst_we", 16'(MEM_WE), 16'h0);
    check("rst_inc", 16'(INC_EN), 16'h0);
    check("rst_halt", 16'(HALT), 16'h0);
`ifdef SUBLEQ_RETIRE_CNT_EN
    check("rst_retired", RETIRED, 16'h0);
`endif
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("idle_inc", 16'(INC_EN), 16'h0);
    end

    // Table-driven single instructions.
    for (int i = 0; i < 7; i++) begin
      reset_load_run(vecs[i]);
      check($sformatf("v%0d_fa_addr", i), 16'(MEM_ADDR), 16'h0);
      check($sformatf("v%0d_fa_inc", i), 16'(INC_EN), 16'h1);
      repeat (9) tick;
      check($sformatf("v%0d_wb_addr", i), 16'(MEM_ADDR), 16'(vecs[i].op_b));
      check($sformatf("v%0d_wb_dout", i), 16'(MEM_DOUT), 16'(vecs[i].exp_dout));
      check($sformatf("v%0d_wb_we", i), 16'(MEM_WE), 16'h1);
      tick;
      check($sformatf("v%0d_pc", i), 16'(PC), 16'(vecs[i].exp_pc));
      check($sformatf("v%0d_fa2_addr", i), 16'(MEM_ADDR), 16'(vecs[i].exp_pc));
      check($sformatf("v%0d_mem", i), 16'(mem[vecs[i].op_b]), 16'(vecs[i].exp_dout));
      check($sformatf("v%0d_halt", i), 16'(HALT), 16'h0);
`ifdef SUBLEQ_RETIRE_CNT_EN
      check($sformatf("v%0d_retired", i), RETIRED, 16'h1);
`endif
    end

    // A taken branch to 0xFF halts the core, and it stays quiet afterwards.
    v = '{8'd10, 8'd11, 8'hFF, 8'd5, 8'd5, 8'h00, 8'hFF};
    reset_load_run(v);
    repeat (9) tick;
    check("halt_wb_we", 16'(MEM_WE), 16'h1);
    tick;
    check("halt_pc", 16'(PC), 16'h00FF);
    for (int i = 0; i < 20; i++) begin
      check("halt_hold", 16'({HALT, MEM_WE, INC_EN}), 16'h4);
      tick;
    end
`ifdef SUBLEQ_RETIRE_CNT_EN
    check("halt_retired", RETIRED, 16'h1);
`endif

    // Branch to 0xFD; the instruction there is not taken and the PC wraps to 0.
    v = '{8'd10, 8'd11, 8'hFD, 8'd5, 8'd5, 8'h00, 8'hFD};
    RST_N = 1'b0;
    poke(8'hFD, 8'd12);
    poke(8'hFE, 8'd13);
    poke(8'hFF, 8'h40);
    poke(8'd12, 8'd1);
    poke(8'd13, 8'd5);
    reset_load_run(v);
    repeat (10) tick;
    check("wrap_fa", 16'(MEM_ADDR), 16'h00FD);
    repeat (2) tick;
    check("wrap_fb", 16'(MEM_ADDR), 16'h00FE);
    repeat (2) tick;
    check("wrap_fc", 16'(MEM_ADDR), 16'h00FF);
    repeat (5) tick;
    check("wrap_wb_dout", 16'(MEM_DOUT), 16'h0004);
    tick;
    check("wrap_next_fa", 16'(MEM_ADDR), 16'h0000);
    check("wrap_pc", 16'(PC), 16'h0000);

    // Self-modifying code: the write to mem[3] changes the next instruction's A operand.
    v = '{8'd10, 8'd3, 8'd20, 8'd1, 8'd12, 8'd11, 8'd3};
    RST_N = 1'b0;
    poke(8'd4, 8'd10);
    poke(8'd5, 8'd11);
    reset_load_run(v);
    repeat (10) tick;
    check("smc_pc", 16'(PC), 16'h0003);
    repeat (6) tick;
    check("smc_ra_addr", 16'(MEM_ADDR), 16'h000B);

    // Reset asserted during WB suppresses the write.
    reset_load_run(vecs[0]);
    repeat (9) tick;
    RST_N = 1'b0;
    #1;
    check("rstwb_we", 16'(MEM_WE), 16'h0);
    check("rstwb_inc", 16'(INC_EN), 16'h0);
    tick;
    RST_N = 1'b1;
    check("rstwb_mem", 16'(mem[11]), 16'h0005);
    check("rstwb_pc", 16'(PC), 16'h0000);
    tick;
    check("rstwb_idle", 16'({INC_EN, MEM_WE, MEM_ADDR}), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
